lcd_row_streamer: RTL
=====================

Name: lcd_row_streamer

Overview:
- Parametrised successor to the UART-to-RAM single-row path. Assembles host pixel bytes from the UART receiver into a ping-pong pair of row buffers.
- For each completed row, issues the full ST7789 window sequence (CASET/RASET/RAMWR) plus the pixel bytes to the 9-bit lcd_write byte interface.
- Returns a flow-control ACK byte to the host each time a row has been flushed to the panel.
- Sits between uart_bus and the control/lcd_write pair, in place of uart_to_ram + lcd_show_row.

Parameters:
- H_RES, 240, pixels per row.
- V_RES, 240, rows per frame; the row index wraps after V_RES-1.
- BPP_BYTES, 2, bytes per pixel (2 = RGB565, 3 = RGB666).
- X_OFFSET, 0, panel column of the first pixel.
- Y_OFFSET, 0, panel row of row 0.
- ACK_BYTE, 8'h06, byte sent on tx after each flushed row.

Ports:
- sys_clk  in  1  system clock (50 MHz domain); the block uses one clock only.
- sys_rst  in  1  reset, synchronous to sys_clk, active-high.
- init_done  in  1  panel initialised; no en_write is issued while low.
- frame_sync  in  1  one-cycle pulse; restarts the frame at row 0.
- rx_data_valid  in  1  one-cycle strobe, rx_data_out valid.
- rx_data_out  in  8  host pixel byte.
- tx_data_valid  out  1  one-cycle strobe for the ACK byte.
- tx_data_out  out  8  ACK byte.
- wr_data  out  9  bit8 = dc (0 = command, 1 = data), bits7:0 = byte.
- en_write  out  1  one-cycle request to lcd_write.
- wr_done  in  1  one-cycle pulse, byte shifted out.
- row_idx  out  clog2(V_RES)  row currently or next displayed.
- busy  out  1  display FSM not in IDLE.
- overflow  out  1  sticky; a byte arrived while both banks were full.
- frame_done  out  1  one-cycle pulse after the last byte of row V_RES-1.

Behaviour:
- Reset (sys_rst high at a clock edge) clears the following, all to 0: tx_data_valid, tx_data_out, wr_data, en_write, row_idx, busy, overflow, frame_done, both bank-full flags, fill pointer, fill bank, FSM state (IDLE). Buffer RAM contents are don't-care.
- Buffer: 2 x (H_RES*BPP_BYTES) bytes, single-port-write/single-port-read, registered read (1-cycle latency).
- Fill side:
  - Each rx_data_valid writes the byte to fill_bank at fill_ptr, then fill_ptr++.
  - At fill_ptr = H_RES*BPP_BYTES-1 the write sets full[fill_bank], clears fill_ptr and toggles fill_bank.
  - If full[fill_bank] is already set on arrival, the byte is dropped and overflow is set (sticky until reset).
- Display FSM:
  - IDLE: when init_done=1 and full[disp_bank]=1 -> HDR with k=0. busy=1 from this next cycle.
  - HDR: drive header byte k with en_write for one cycle, then wait for wr_done; k++. After k=10 -> PIX_RD.
  - Header sequence: 0x02A, {1,xs[15:8]}, {1,xs[7:0]}, {1,xe[15:8]}, {1,xe[7:0]}, 0x02B, {1,ys[15:8]}, {1,ys[7:0]}, {1,ys[15:8]}, {1,ys[7:0]}, 0x02C.
  - Header values: xs = X_OFFSET, xe = X_OFFSET+H_RES-1, ys = Y_OFFSET+row_idx. All are 16-bit, truncated modulo 2^16.
  - PIX_RD: present the read address; next cycle -> PIX_WR.
  - PIX_WR: en_write with wr_data={1,q} for one cycle, then wait for wr_done. If not the last byte -> PIX_RD with addr++, else -> ROW_END.
  - ROW_END (one cycle):
    - clear full[disp_bank] and toggle disp_bank;
    - pulse tx_data_valid with tx_data_out=ACK_BYTE;
    - if row_idx = V_RES-1: row_idx <= 0 and pulse frame_done, else row_idx++;
    - -> IDLE.
- en_write is never high for two consecutive cycles. A new request is issued only after the wr_done for the previous one. A wr_done seen outside a wait state is ignored.
- Fill and display run concurrently on different banks. If ROW_END frees a bank in the same cycle a byte arrives for it, that byte is accepted, not dropped.
- frame_sync:
  - In IDLE: row_idx <= 0, fill_ptr <= 0, both full flags cleared, both bank pointers <= 0.
  - Outside IDLE: latched and applied on the cycle after ROW_END; that row's ACK is still sent.
  - A frame_sync coincident with rx_data_valid: the frame_sync takes effect and the byte is written at address 0 of bank 0.
- init_done low: filling continues (up to two rows); display waits in IDLE.

Test Plan:
- Reset: hold sys_rst 2 cycles mid-row (H_RES=4, BPP_BYTES=2) -> all outputs 0, overflow 0, next 8 bytes fill bank 0 from address 0.
- Single row (H_RES=4, BPP_BYTES=2, X_OFFSET=0, Y_OFFSET=0, wr_done returned 3 cycles after each en_write), bytes 0x11..0x18:
  - wr_data = 0x02A, 0x100, 0x100, 0x100, 0x103, 0x02B, 0x100 x4, 0x02C, then 0x111..0x118;
  - one tx pulse 0x06; row_idx then 1.
- Overflow: init_done=0, send 24 bytes -> first 16 stored, overflow=1 and stays 1. Raise init_done -> two rows displayed, two ACKs.
- Wrap (V_RES=2): stream 3 rows -> ys bytes 0x100 / 0x101 / 0x100; frame_done pulses exactly once, after row 1's last wr_done.
- frame_sync during PIX_WR of row 0 -> row 0 completes with its ACK, then row_idx=0; the next row's header carries ys=0.
- Protocol check: random wr_done delays of 1-20 cycles -> en_write never high on consecutive cycles and never re-asserted before wr_done.

Source files
------------

// File: rtl/lcd_row_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_row_streamer
//  Description : Collects host pixel bytes from the UART receiver into a
//                ping-pong pair of row buffers. Each completed row is sent to
//                the 9-bit lcd_write interface as an ST7789 CASET/RASET/RAMWR
//                window header followed by the row's pixel bytes. After each
//                row is flushed, one ACK byte is returned to the host.
//  Ports       : sys_clk/sys_rst      - clock, synchronous active-high reset
//                init_done            - panel ready; display holds in IDLE
//                                       while low
//                frame_sync           - restart the frame at row 0
//                rx_data_valid/out    - incoming host byte
//                tx_data_valid/out    - ACK byte back to the host
//                wr_data/en_write     - {dc, byte} request to lcd_write
//                wr_done              - lcd_write finished the last request
//                row_idx, busy, overflow, frame_done - status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_row_streamer #(
    parameter int         H_RES     = 240,
    parameter int         V_RES     = 240,
    parameter int         BPP_BYTES = 2,
    parameter int         X_OFFSET  = 0,
    parameter int         Y_OFFSET  = 0,
    parameter logic [7:0] ACK_BYTE  = 8'h06
) (
    input  logic                                       sys_clk,
    input  logic                                       sys_rst,
    input  logic                                       init_done,
    input  logic                                       frame_sync,
    input  logic                                       rx_data_valid,
    input  logic [7:0]                                 rx_data_out,
    output logic                                       tx_data_valid,
    output logic [7:0]                                 tx_data_out,
    output logic [8:0]                                 wr_data,
    output logic                                       en_write,
    input  logic                                       wr_done,
    output logic [$clog2((V_RES > 1) ? V_RES : 2)-1:0] row_idx,
    output logic                                       busy,
    output logic                                       overflow,
    output logic                                       frame_done
);

    localparam int c_ROW_BYTES = H_RES * BPP_BYTES;
    localparam int c_BUF_BYTES = 2 * c_ROW_BYTES;
    localparam int c_PW        = (c_ROW_BYTES > 1) ? $clog2(c_ROW_BYTES) : 1;
    localparam int c_AW        = $clog2(c_BUF_BYTES);
    localparam int c_ROW_W     = $clog2((V_RES > 1) ? V_RES : 2);

    localparam logic [c_PW-1:0]    c_LAST_PTR = c_PW'(c_ROW_BYTES - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(V_RES - 1);
    localparam logic [15:0]        c_XS       = 16'(X_OFFSET);
    localparam logic [15:0]        c_XE       = 16'(X_OFFSET + H_RES - 1);
    localparam logic [3:0]         c_HDR_LAST = 4'd10;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_HDR      = 3'd1;
    localparam logic [2:0] c_ST_HDR_WAIT = 3'd2;
    localparam logic [2:0] c_ST_PIX_RD   = 3'd3;
    localparam logic [2:0] c_ST_PIX_WR   = 3'd4;
    localparam logic [2:0] c_ST_PIX_WAIT = 3'd5;
    localparam logic [2:0] c_ST_ROW_END  = 3'd6;

    logic [7:0]         r_mem [0:c_BUF_BYTES-1];
    logic [7:0]         r_q;

    logic [2:0]         r_state;
    logic [3:0]         r_hdr_k;
    logic [c_PW-1:0]    r_pix_ptr;
    logic [c_PW-1:0]    r_fill_ptr;
    logic               r_fill_bank;
    logic               r_disp_bank;
    logic [1:0]         r_full;
    logic               r_fs_pending;
    logic [c_ROW_W-1:0] r_row_idx;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic [8:0]         r_wr_data;
    logic               r_en_write;
    logic               r_busy;
    logic               r_overflow;
    logic               r_frame_done;

    logic               w_sync_apply;
    logic [1:0]         w_clr_mask;
    logic [1:0]         w_full_eff;
    logic [1:0]         w_full_next;
    logic               w_fill_bank_eff;
    logic [c_PW-1:0]    w_fill_ptr_eff;
    logic               w_accept;
    logic               w_drop;
    logic               w_fill_last;
    logic [c_AW-1:0]    w_wr_addr;
    logic [c_AW-1:0]    w_rd_addr;
    logic [15:0]        w_ys;
    logic [8:0]         w_hdr;

    // A frame restart only takes effect while the display side is idle;
    // one requested mid-row waits in r_fs_pending until the row is flushed.
    assign w_sync_apply = (r_state == c_ST_IDLE) && (frame_sync || r_fs_pending);

    // The bank released by ROW_END is already free for a byte arriving in
    // the same cycle, so the fill side looks at the post-release flags.
    assign w_clr_mask = (r_state == c_ST_ROW_END) ? (r_disp_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_eff = w_sync_apply ? 2'b00 : (r_full & ~w_clr_mask);

    assign w_fill_bank_eff = w_sync_apply ? 1'b0 : r_fill_bank;
    assign w_fill_ptr_eff  = w_sync_apply ? '0 : r_fill_ptr;

    assign w_accept    = rx_data_valid && !(w_fill_bank_eff ? w_full_eff[1] : w_full_eff[0]);
    assign w_drop      = rx_data_valid && !w_accept;
    assign w_fill_last = w_accept && (w_fill_ptr_eff == c_LAST_PTR);
    assign w_full_next = w_full_eff |
                         (w_fill_last ? (w_fill_bank_eff ? 2'b10 : 2'b01) : 2'b00);

    assign w_wr_addr = w_fill_bank_eff ? (c_AW'(c_ROW_BYTES) + c_AW'(w_fill_ptr_eff))
                                       : c_AW'(w_fill_ptr_eff);
    assign w_rd_addr = r_disp_bank ? (c_AW'(c_ROW_BYTES) + c_AW'(r_pix_ptr))
                                   : c_AW'(r_pix_ptr);

    assign w_ys = 16'(Y_OFFSET) + 16'(r_row_idx);

    always_comb begin
        w_hdr = 9'h000;
        case (r_hdr_k)
            4'd0:    w_hdr = 9'h02A;
            4'd1:    w_hdr = {1'b1, c_XS[15:8]};
            4'd2:    w_hdr = {1'b1, c_XS[7:0]};
            4'd3:    w_hdr = {1'b1, c_XE[15:8]};
            4'd4:    w_hdr = {1'b1, c_XE[7:0]};
            4'd5:    w_hdr = 9'h02B;
            4'd6:    w_hdr = {1'b1, w_ys[15:8]};
            4'd7:    w_hdr = {1'b1, w_ys[7:0]};
            4'd8:    w_hdr = {1'b1, w_ys[15:8]};
            4'd9:    w_hdr = {1'b1, w_ys[7:0]};
            4'd10:   w_hdr = 9'h02C;
            default: w_hdr = 9'h000;
        endcase
    end

    // Row buffer: one write port (fill), one registered read port (display).
    always_ff @(posedge sys_clk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= rx_data_out;
        end
        r_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= c_ST_IDLE;
            r_hdr_k      <= 4'd0;
            r_pix_ptr    <= '0;
            r_fill_ptr   <= '0;
            r_fill_bank  <= 1'b0;
            r_disp_bank  <= 1'b0;
            r_full       <= 2'b00;
            r_fs_pending <= 1'b0;
            r_row_idx    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_wr_data    <= 9'h000;
            r_en_write   <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_en_write   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b0;

            // Fill side
            r_full <= w_full_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                if (w_fill_last) begin
                    r_fill_ptr  <= '0;
                    r_fill_bank <= ~w_fill_bank_eff;
                end else begin
                    r_fill_ptr  <= w_fill_ptr_eff + 1'b1;
                    r_fill_bank <= w_fill_bank_eff;
                end
            end else if (w_sync_apply) begin
                r_fill_ptr  <= '0;
                r_fill_bank <= 1'b0;
            end

            if ((r_state != c_ST_IDLE) && frame_sync) begin
                r_fs_pending <= 1'b1;
            end

            // Display side
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sync_apply) begin
                        r_row_idx    <= '0;
                        r_disp_bank  <= 1'b0;
                        r_fs_pending <= 1'b0;
                    end else if (init_done && r_full[r_disp_bank]) begin
                        r_hdr_k <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_HDR;
                    end
                end
                c_ST_HDR: begin
                    r_wr_data  <= w_hdr;
                    r_en_write <= 1'b1;
                    r_state    <= c_ST_HDR_WAIT;
                end
                c_ST_HDR_WAIT: begin
                    if (wr_done) begin
                        if (r_hdr_k == c_HDR_LAST) begin
                            r_pix_ptr <= '0;
                            r_state   <= c_ST_PIX_RD;
                        end else begin
                            r_hdr_k <= r_hdr_k + 4'd1;
                            r_state <= c_ST_HDR;
                        end
                    end
                end
                c_ST_PIX_RD: begin
                    // read address settles this cycle; r_q is valid in PIX_WR
                    r_state <= c_ST_PIX_WR;
                end
                c_ST_PIX_WR: begin
                    r_wr_data  <= {1'b1, r_q};
                    r_en_write <= 1'b1;
                    r_state    <= c_ST_PIX_WAIT;
                end
                c_ST_PIX_WAIT: begin
                    if (wr_done) begin
                        if (r_pix_ptr == c_LAST_PTR) begin
                            r_state <= c_ST_ROW_END;
                        end else begin
                            r_pix_ptr <= r_pix_ptr + 1'b1;
                            r_state   <= c_ST_PIX_RD;
                        end
                    end
                end
                c_ST_ROW_END: begin
                    r_disp_bank <= ~r_disp_bank;
                    r_tx_valid  <= 1'b1;
                    r_tx_data   <= ACK_BYTE;
                    if (r_row_idx == c_LAST_ROW) begin
                        r_row_idx    <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row_idx <= r_row_idx + 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data_valid = r_tx_valid;
    assign tx_data_out   = r_tx_data;
    assign wr_data       = r_wr_data;
    assign en_write      = r_en_write;
    assign row_idx       = r_row_idx;
    assign busy          = r_busy;
    assign overflow      = r_overflow;
    assign frame_done    = r_frame_done;

endmodule
`default_nettype wire
